// File: rtl/ddr4_cmd_decoder.sv
// DDR4 command decoder: turns four 32-bit command slots per beat into registered 4-phase DFI pins.
// Latency: command pins 1 cycle; wrdata 1+WL_CYCLES cycles; rddata_en 1+RL_CYCLES cycles.
// Backpressure: none. Every valid beat is accepted, and each delay line takes at most one entry per cycle.
module ddr4_cmd_decoder #(
  parameter int NUM_SLOTS   = 4,
  parameter int WDATA_WIDTH = 512,
  parameter int ADDR_WIDTH  = 17,
  parameter int WL_CYCLES   = 4,
  parameter int RL_CYCLES   = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_SLOTS*32+WDATA_WIDTH-1:0] in_data,
  input  logic                               in_valid,
  output logic [NUM_SLOTS-1:0]               dfi_cs_n,
  output logic [NUM_SLOTS-1:0]               dfi_act_n,
  output logic [NUM_SLOTS-1:0]               dfi_ras_n,
  output logic [NUM_SLOTS-1:0]               dfi_cas_n,
  output logic [NUM_SLOTS-1:0]               dfi_we_n,
  output logic [2*NUM_SLOTS-1:0]             dfi_bg,
  output logic [2*NUM_SLOTS-1:0]             dfi_ba,
  output logic [ADDR_WIDTH*NUM_SLOTS-1:0]    dfi_address,
  output logic                               dfi_wrdata_en,
  output logic [WDATA_WIDTH-1:0]             dfi_wrdata,
  output logic                               dfi_rddata_en,
  output logic [31:0]                        rd_count,
  output logic [31:0]                        wr_count,
  output logic                               multi_wr_err
);

  localparam logic [2:0] OP_ACT  = 3'd1;
  localparam logic [2:0] OP_PRE  = 3'd2;
  localparam logic [2:0] OP_RD   = 3'd3;
  localparam logic [2:0] OP_WR   = 3'd4;
  localparam logic [2:0] OP_REF  = 3'd5;
  localparam logic [2:0] OP_PREA = 3'd6;
  localparam int         SLOT_BITS = NUM_SLOTS * 32;

  logic [NUM_SLOTS-1:0]            cs_n_d, act_n_d, ras_n_d, cas_n_d, we_n_d;
  logic [NUM_SLOTS-1:0]            cs_n_q, act_n_q, ras_n_q, cas_n_q, we_n_q;
  logic [2*NUM_SLOTS-1:0]          bg_d, ba_d, bg_q, ba_q;
  logic [ADDR_WIDTH*NUM_SLOTS-1:0] addr_d, addr_q;
  logic [31:0]                     rd_count_d, rd_count_q, wr_count_d, wr_count_q;
  logic                            err_d, err_q;
  logic [2:0]                      n_wr, n_rd;
  logic [24:0]                     slot;
  logic [NUM_SLOTS*7-1:0]          unused_slot_bits;

  // Write-data and read-strobe delay lines; the last stage drives the outputs directly.
  logic [WL_CYCLES:0]              wr_en_q;
  logic [WDATA_WIDTH-1:0]          wr_dat_q [WL_CYCLES+1];
  logic [RL_CYCLES:0]              rd_en_q;

  // Slot bits [31:25] carry no meaning.
  always_comb begin
    unused_slot_bits = '0;
    for (int k = 0; k < NUM_SLOTS; k++) unused_slot_bits[7*k +: 7] = in_data[32*k+25 +: 7];
  end

  // Decode each slot into its phase pins and tally RD/WR slots in the beat.
  always_comb begin
    cs_n_d  = '1;
    act_n_d = '1;
    ras_n_d = '1;
    cas_n_d = '1;
    we_n_d  = '1;
    bg_d    = '0;
    ba_d    = '0;
    addr_d  = '0;
    n_wr    = '0;
    n_rd    = '0;
    slot    = '0;
    for (int k = 0; k < NUM_SLOTS; k++) begin
      slot = in_data[32*k +: 25];
      if (in_valid && slot[2:0] != 3'd0 && slot[2:0] != 3'd7) begin
        cs_n_d[k]        = 1'b0;
        bg_d[2*k +: 2]   = slot[4:3];
        ba_d[2*k +: 2]   = slot[6:5];
      end
      if (in_valid) begin
        case (slot[2:0])
          OP_ACT: begin
            act_n_d[k] = 1'b0;
            ras_n_d[k] = slot[23];
            cas_n_d[k] = slot[22];
            we_n_d[k]  = slot[21];
            addr_d[ADDR_WIDTH*k +: ADDR_WIDTH] = ADDR_WIDTH'(slot[23:7]);
          end
          OP_PRE: begin
            ras_n_d[k] = 1'b0;
            we_n_d[k]  = 1'b0;
          end
          OP_PREA: begin
            ras_n_d[k] = 1'b0;
            we_n_d[k]  = 1'b0;
            addr_d[ADDR_WIDTH*k + 10] = 1'b1;
          end
          OP_RD, OP_WR: begin
            cas_n_d[k] = 1'b0;
            we_n_d[k]  = (slot[2:0] == OP_RD);
            addr_d[ADDR_WIDTH*k +: 10] = slot[16:7];
            addr_d[ADDR_WIDTH*k + 10]  = slot[24];
            addr_d[ADDR_WIDTH*k + 12]  = 1'b1;   // BL8
            if (slot[2:0] == OP_RD) n_rd = n_rd + 3'd1;
            else                    n_wr = n_wr + 3'd1;
          end
          OP_REF: begin
            ras_n_d[k] = 1'b0;
            cas_n_d[k] = 1'b0;
          end
          default: ;
        endcase
      end
    end
    rd_count_d = rd_count_q + 32'(n_rd);
    wr_count_d = wr_count_q + 32'(n_wr);
    err_d      = err_q | (n_wr > 3'd1);
  end

  // Command pins, statistics and the sticky multi-WR flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_n_q     <= '1;
      act_n_q    <= '1;
      ras_n_q    <= '1;
      cas_n_q    <= '1;
      we_n_q     <= '1;
      bg_q       <= '0;
      ba_q       <= '0;
      addr_q     <= '0;
      rd_count_q <= '0;
      wr_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cs_n_q     <= cs_n_d;
      act_n_q    <= act_n_d;
      ras_n_q    <= ras_n_d;
      cas_n_q    <= cas_n_d;
      we_n_q     <= we_n_d;
      bg_q       <= bg_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
      err_q      <= err_d;
    end
  end

  // Delay lines: one entry per beat; data is zeroed for non-WR beats so idle output stays 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q <= '0;
      rd_en_q <= '0;
      for (int i = 0; i <= WL_CYCLES; i++) wr_dat_q[i] <= '0;
    end else begin
      wr_en_q[0]  <= (n_wr != 3'd0);
      wr_dat_q[0] <= (n_wr != 3'd0) ? in_data[SLOT_BITS +: WDATA_WIDTH] : '0;
      rd_en_q[0]  <= (n_rd != 3'd0);
      for (int i = 1; i <= WL_CYCLES; i++) begin
        wr_en_q[i]  <= wr_en_q[i-1];
        wr_dat_q[i] <= wr_dat_q[i-1];
      end
      for (int i = 1; i <= RL_CYCLES; i++) rd_en_q[i] <= rd_en_q[i-1];
    end
  end

  assign dfi_cs_n      = cs_n_q;
  assign dfi_act_n     = act_n_q;
  assign dfi_ras_n     = ras_n_q;
  assign dfi_cas_n     = cas_n_q;
  assign dfi_we_n      = we_n_q;
  assign dfi_bg        = bg_q;
  assign dfi_ba        = ba_q;
  assign dfi_address   = addr_q;
  assign dfi_wrdata_en = wr_en_q[WL_CYCLES];
  assign dfi_wrdata    = wr_dat_q[WL_CYCLES];
  assign dfi_rddata_en = rd_en_q[RL_CYCLES];
  assign rd_count      = rd_count_q;
  assign wr_count      = wr_count_q;
  assign multi_wr_err  = err_q;

endmodule
